regulator_ctrl: RTL
===================

# regulator_ctrl

Sequencer and heater controller for the temperature regulator. Paces ADC conversions from a free-running sample tick and runs a start/done handshake with a conversion timeout. Averages four consecutive samples and compares the average with the 8-bit setpoint using hysteresis. Drives the heater output subject to a minimum dwell time. Sits between the setpoint register and ADC front end on one side and the heater driver and display path on the other.

## Interface

Parameters:
- SAMPLE_DIV, 50000 — clk cycles per sample tick (≥ 8).
- HYST, 2 — hysteresis band in temperature LSBs (0..15).
- MIN_DWELL, 1000 — minimum sample ticks between heater changes (1..65535).
- TIMEOUT, 4096 — clk cycles allowed in WAIT before fault (≥ 2).

Ports:
- clk  in  1  system clock, all state on rising edge.
- clr  in  1  asynchronous active-low reset.
- en  in  1  enables starting new conversions.
- setpoint  in  8  target temperature, unsigned.
- adc_data  in  8  converted temperature, valid while adc_done=1.
- adc_done  in  1  one-cycle conversion-complete pulse.
- adc_start  out  1  one-cycle conversion request.
- temp  out  8  last 4-sample average.
- temp_valid  out  1  one-cycle pulse when temp updates.
- heater  out  1  heater drive, 1 = on.
- fault  out  1  sticky conversion-timeout flag.

## Operation

- Tick counter 0..SAMPLE_DIV-1, free-running, wraps. tick = 1 when count = SAMPLE_DIV-1.
- FSM states: IDLE, START, WAIT, ACC, EVAL, FAULT.
  - IDLE: if tick & en → START; else stay.
  - START: adc_start = 1 for this cycle only; clear timeout counter; → WAIT.
  - WAIT: if adc_done → capture adc_data, → ACC. Else if timeout counter = TIMEOUT-1 → FAULT. Else increment.
  - ACC: acc (10 bit) += sample; idx (2 bit) += 1. If idx was 3 → EVAL, else IDLE.
  - EVAL: avg = acc[9:2]. Load temp, pulse temp_valid, run heater decision. Clear acc and idx. → IDLE.
  - FAULT: heater = 0, fault = 1, adc_start = 0. Terminal until clr.
- Heater decision, 9-bit unsigned arithmetic with no wrap:
  - want_on if avg + HYST ≤ setpoint.
  - want_off if avg ≥ setpoint + HYST.
  - Otherwise hold.
- Dwell counter: 16-bit, increments on each tick, saturates at MIN_DWELL. Heater changes only if dwell = MIN_DWELL and the request differs from current heater. On a change, dwell → 0.
- Boundary cases:
  - tick outside IDLE: dropped, not queued.
  - en deasserted mid-sequence: current conversion completes, and EVAL runs if idx reaches 4. Only the exit from IDLE is gated.
  - adc_done outside WAIT: ignored.
  - adc_done on the same cycle as timeout expiry: done wins.
  - setpoint change: takes effect at next EVAL only.
  - clr asserted in any state: immediate return to reset values. Partial accumulation is discarded.

## Timing

- Reset values:
  - Outputs: adc_start 0, temp 0, temp_valid 0, heater 0, fault 0.
  - Internal: state IDLE, tick counter 0, acc 0, idx 0, timeout counter 0, dwell = MIN_DWELL (saturated, so the first decision may act immediately).
- All outputs are registered.
- adc_start is high in the cycle after the tick cycle.
- If adc_done is high in cycle k: state is ACC in k+1 and EVAL in k+2. temp, temp_valid and heater change at the end of EVAL and are visible in cycle k+3.
- Minimum period of one full sequence is 5 cycles, always shorter than SAMPLE_DIV.
- fault rises the cycle after the WAIT cycle where the timeout counter = TIMEOUT-1. heater is 0 in that same cycle.

## Test plan

Bench parameters: SAMPLE_DIV=16, HYST=2, MIN_DWELL=3, TIMEOUT=32. The ADC model returns done 4 cycles after start unless stated otherwise.

1. Reset, en=1, setpoint=30, samples 20,21,22,23 → adc_start once per tick, temp_valid after 4th sample with temp=21, heater=1.
2. Heater on, setpoint=30, averages 29 then 31 then 32 → heater holds 1, holds 1, then goes 0 (dwell saturated).
3. Dwell: after a change, an average of 40 with setpoint=30 arriving within 3 ticks → heater unchanged until dwell reaches 3, then 0 at the next EVAL.
4. Saturation: setpoint=255, samples 255×4 → temp=255, heater holds (257 comparisons do not wrap).
5. Timeout: ADC never asserts done → fault=1 and heater=0 exactly 32 cycles after WAIT entry, no further adc_start until clr.
6. clr low during WAIT after 2 accepted samples, then release → all outputs 0, and the next average uses 4 fresh samples only.

Source files
------------

// File: rtl/regulator_ctrl.sv
// -----------------------------------------------------------------------------
// regulator_ctrl
//
// Sequencer and heater controller for the temperature regulator.
//   - Paces ADC conversions from a free-running sample tick.
//   - Runs a start/done handshake with the ADC, with a conversion timeout.
//   - Averages four consecutive samples into an 8-bit temperature.
//   - Compares the average with the setpoint using a hysteresis band.
//   - Drives the heater, allowing a change only after a minimum dwell.
//
// Parameters:
//   SAMPLE_DIV  clk cycles per sample tick (>= 8)
//   HYST        hysteresis band in temperature LSBs (0..15)
//   MIN_DWELL   minimum sample ticks between heater changes (1..65535)
//   TIMEOUT     clk cycles allowed waiting for adc_done before faulting (>= 2)
//
// Ports:
//   clk         system clock, all state on rising edge
//   clr         asynchronous active-low reset
//   en          enables starting new conversions
//   setpoint    target temperature, unsigned
//   adc_data    converted temperature, valid while adc_done = 1
//   adc_done    one-cycle conversion-complete pulse
//   adc_start   one-cycle conversion request (registered)
//   temp        last 4-sample average (registered)
//   temp_valid  one-cycle pulse when temp updates (registered)
//   heater      heater drive, 1 = on (registered)
//   fault       sticky conversion-timeout flag (registered)
// -----------------------------------------------------------------------------
module regulator_ctrl #(
   parameter int unsigned SAMPLE_DIV = 50000,
   parameter int unsigned HYST       = 2,
   parameter int unsigned MIN_DWELL  = 1000,
   parameter int unsigned TIMEOUT    = 4096
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       en,
   input  logic [7:0] setpoint,
   input  logic [7:0] adc_data,
   input  logic       adc_done,
   output logic       adc_start,
   output logic [7:0] temp,
   output logic       temp_valid,
   output logic       heater,
   output logic       fault
);

   localparam int TICK_W = $clog2(SAMPLE_DIV);
   localparam int TO_W   = $clog2(TIMEOUT);

   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_DIV - 1);
   localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);
   localparam logic [15:0]       DWELL_MAX = 16'(MIN_DWELL);
   localparam logic [8:0]        HYST9     = 9'(HYST);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_WAIT,
      S_ACC,
      S_EVAL,
      S_FAULT
   } state_t;

   state_t            state;
   state_t            next_state;
   logic [TICK_W-1:0] tick_cnt;
   logic              tick;
   logic [TO_W-1:0]   to_cnt;
   logic [7:0]        sample;
   logic [9:0]        acc;
   logic [1:0]        idx;
   logic [15:0]       dwell;

   logic [7:0]        avg;
   logic              want_on;
   logic              want_off;
   logic              do_change;

   assign tick = (tick_cnt == TICK_LAST);

   // Heater decision. Both sides are widened to 9 bits so that avg + HYST and
   // setpoint + HYST cannot wrap near full scale.
   assign avg       = acc[9:2];
   assign want_on   = ({1'b0, avg} + HYST9) <= {1'b0, setpoint};
   assign want_off  = {1'b0, avg} >= ({1'b0, setpoint} + HYST9);
   assign do_change = (state == S_EVAL) && (dwell == DWELL_MAX) &&
                      ((want_on && !heater) || (want_off && heater));

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable assigned here gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      next_state = state;
      case (state)
         S_IDLE:  if (tick && en) next_state = S_START;
         S_START: next_state = S_WAIT;
         S_WAIT: begin
            // A done arriving on the last allowed cycle still wins.
            if (adc_done)               next_state = S_ACC;
            else if (to_cnt == TO_LAST) next_state = S_FAULT;
         end
         S_ACC:   next_state = (idx == 2'd3) ? S_EVAL : S_IDLE;
         S_EVAL:  next_state = S_IDLE;
         S_FAULT: next_state = S_FAULT;
         default: next_state = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // State register and free-running sample tick
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state    <= S_IDLE;
         tick_cnt <= '0;
      end else begin
         // NOTE: clocked state uses non-blocking assignments so every register
         // samples the pre-edge values, independent of statement order.
         state    <= next_state;
         tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Conversion datapath: timeout counter, sample capture, accumulator
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         to_cnt <= '0;
         sample <= '0;
         acc    <= '0;
         idx    <= '0;
      end else begin
         case (state)
            S_START: to_cnt <= '0;
            S_WAIT: begin
               if (adc_done)               sample <= adc_data;
               else if (to_cnt != TO_LAST) to_cnt <= to_cnt + 1'b1;
            end
            S_ACC: begin
               acc <= acc + {2'b00, sample};
               idx <= idx + 2'd1;
            end
            S_EVAL: begin
               acc <= '0;
               idx <= '0;
            end
            default: ;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Registered outputs and heater dwell timer
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         adc_start  <= 1'b0;
         temp       <= '0;
         temp_valid <= 1'b0;
         heater     <= 1'b0;
         fault      <= 1'b0;
         // Starts saturated so the first decision after reset may act at once.
         dwell      <= DWELL_MAX;
      end else begin
         adc_start  <= (next_state == S_START);
         temp_valid <= (state == S_EVAL);

         if (state == S_EVAL) temp <= avg;

         // Entering FAULT forces the heater off in the same cycle fault rises;
         // FAULT only leaves on clr, so both stay put from then on.
         if (next_state == S_FAULT) begin
            heater <= 1'b0;
            fault  <= 1'b1;
         end else if (do_change) begin
            heater <= ~heater;
         end

         if (do_change)                      dwell <= '0;
         else if (tick && dwell != DWELL_MAX) dwell <= dwell + 16'd1;
      end
   end

endmodule
